tx_beacon_sched: RTL and testbench

TX_BEACON_SCHED -- requirements
Module: tx_beacon_sched

---
 rtl/tx_beacon_sched.sv | 112 +++++++++++
 tb/tb_tx_beacon_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_beacon_sched.sv
// Periodic beacon scheduler: writes a small payload into the TX buffer, pulses
// a start, then tracks SFD/END events from the radio with a timeout guard.
module tx_beacon_sched #(
    parameter logic [23:0] PERIOD  = 24'd1000000,
    parameter logic [6:0]  PLD_LEN = 7'd4,
    parameter logic [23:0] TIMEOUT = 24'd500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic [7:0]  i_node_id,
    input  logic [2:0]  i_ev,
    input  logic        i_ev_sig,
    output logic        o_start,
    output logic        o_buf_w_en,
    output logic [6:0]  o_buf_w_addr,
    output logic [7:0]  o_buf_byte,
    output logic        o_tx_ind,
    output logic        o_tx_sfd,
    output logic        o_busy,
    output logic        o_timeout,
    output logic        o_overrun,
    output logic [15:0] o_seq
);
    // Event codes shared with the radio TX core (tx.vh).
    localparam logic [2:0] TX_EVENT_SFD = 3'd1;
    localparam logic [2:0] TX_EVENT_END = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_PERIOD, S_LOAD, S_START, S_WAIT_TX
    } state_t;

    state_t      r_state, w_nstate;
    logic [23:0] r_pcnt;
    logic [23:0] r_wcnt;
    logic [6:0]  r_lcnt;
    logic [15:0] r_seq;
    logic        r_ind, r_sfd, r_timeout, r_overrun;

    logic w_tick, w_busy, w_end, w_sfd, w_to, w_load_last;

    assign w_busy      = (r_state == S_LOAD) || (r_state == S_START) || (r_state == S_WAIT_TX);
    assign w_tick      = (r_state != S_IDLE) && (r_pcnt == PERIOD - 24'd1);
    assign w_end       = (r_state == S_WAIT_TX) && i_ev_sig && (i_ev == TX_EVENT_END);
    assign w_sfd       = (r_state == S_WAIT_TX) && i_ev_sig && (i_ev == TX_EVENT_SFD);
    // END wins over a coincident timeout.
    assign w_to        = (r_state == S_WAIT_TX) && !w_end && (r_wcnt == TIMEOUT - 24'd1);
    assign w_load_last = (r_lcnt == PLD_LEN - 7'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pcnt    <= '0;
            r_wcnt    <= '0;
            r_lcnt    <= '0;
            r_seq     <= '0;
            r_ind     <= 1'b0;
            r_sfd     <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_pcnt    <= (r_state == S_IDLE || w_tick) ? 24'd0 : r_pcnt + 24'd1;
            r_lcnt    <= (r_state == S_LOAD && !w_load_last) ? r_lcnt + 7'd1 : 7'd0;
            r_wcnt    <= (r_state == S_WAIT_TX) ? r_wcnt + 24'd1 : 24'd0;
            r_timeout <= w_to;
            r_overrun <= w_tick && w_busy;
            if (w_end || w_to) r_sfd <= 1'b0;
            else if (w_sfd)    r_sfd <= 1'b1;
            if (w_end) begin
                r_ind <= ~r_ind;
                r_seq <= r_seq + 16'd1;
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE:        if (i_enable) w_nstate = S_LOAD;
            S_WAIT_PERIOD: if (!i_enable) w_nstate = S_IDLE;
                           else if (w_tick) w_nstate = S_LOAD;
            S_LOAD:        if (w_load_last) w_nstate = S_START;
            S_START:       w_nstate = S_WAIT_TX;
            S_WAIT_TX:     if (w_end || w_to) w_nstate = i_enable ? S_WAIT_PERIOD : S_IDLE;
            default:       w_nstate = S_IDLE;
        endcase
    end

    always_comb begin
        o_start      = (r_state == S_START);
        o_buf_w_en   = (r_state == S_LOAD);
        o_buf_w_addr = r_lcnt;
        o_busy       = w_busy;
        o_buf_byte   = 8'h00;
        if (r_state == S_LOAD) begin
            case (r_lcnt)
                7'd0:    o_buf_byte = 8'hA5;
                7'd1:    o_buf_byte = i_node_id;
                7'd2:    o_buf_byte = r_seq[15:8];
                7'd3:    o_buf_byte = r_seq[7:0];
                default: o_buf_byte = 8'h00;
            endcase
        end
    end

    assign o_tx_ind  = r_ind;
    assign o_tx_sfd  = r_sfd;
    assign o_timeout = r_timeout;
    assign o_overrun = r_overrun;
    assign o_seq     = r_seq;
endmodule

// File: tb/tb_tx_beacon_sched.sv
// Directed bench for tx_beacon_sched: payload scoreboard, period/timeout timing,
// overrun, sequence wrap, enable drop and reset during LOAD.
module tb_tx_beacon_sched;
    localparam logic [2:0] EV_SFD = 3'd1;
    localparam logic [2:0] EV_END = 3'd2;
    localparam logic [2:0] EV_OTHER = 3'd5;

    logic clk = 1'b0;
    logic reset, i_enable, i_enable2, i_ev_sig;
    logic [7:0] i_node_id;
    logic [2:0] i_ev;

    logic o1_start, o1_w_en, o1_ind, o1_sfd, o1_busy, o1_to, o1_ovr;
    logic [6:0] o1_addr;
    logic [7:0] o1_byte;
    logic [15:0] o1_seq;
    logic o2_start, o2_w_en, o2_ind, o2_sfd, o2_busy, o2_to, o2_ovr;
    logic [6:0] o2_addr;
    logic [7:0] o2_byte;
    logic [15:0] o2_seq;

    tx_beacon_sched #(.PERIOD(24'd100), .PLD_LEN(7'd4), .TIMEOUT(24'd50)) dut1 (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_node_id(i_node_id),
        .i_ev(i_ev), .i_ev_sig(i_ev_sig), .o_start(o1_start), .o_buf_w_en(o1_w_en),
        .o_buf_w_addr(o1_addr), .o_buf_byte(o1_byte), .o_tx_ind(o1_ind),
        .o_tx_sfd(o1_sfd), .o_busy(o1_busy), .o_timeout(o1_to),
        .o_overrun(o1_ovr), .o_seq(o1_seq));

    tx_beacon_sched #(.PERIOD(24'd100), .PLD_LEN(7'd4), .TIMEOUT(24'd200)) dut2 (
        .clk(clk), .reset(reset), .i_enable(i_enable2), .i_node_id(i_node_id),
        .i_ev(i_ev), .i_ev_sig(i_ev_sig), .o_start(o2_start), .o_buf_w_en(o2_w_en),
        .o_buf_w_addr(o2_addr), .o_buf_byte(o2_byte), .o_tx_ind(o2_ind),
        .o_tx_sfd(o2_sfd), .o_busy(o2_busy), .o_timeout(o2_to),
        .o_overrun(o2_ovr), .o_seq(o2_seq));

    always #5 clk = ~clk;

    int cyc = 0;
    int n_assert = 0, n_fail = 0;
    int n_start1 = 0, n_start2 = 0, n_ovr1 = 0, n_ovr2 = 0, n_to2 = 0;
    logic [14:0] exp1_q[$];
    logic [14:0] exp2_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pl(input int sel, input logic [15:0] seq);
        logic [14:0] e[4];
        e[0] = {7'd0, 8'hA5};
        e[1] = {7'd1, 8'h3C};
        e[2] = {7'd2, seq[15:8]};
        e[3] = {7'd3, seq[7:0]};
        for (int i = 0; i < 4; i++) begin
            if (sel == 1) exp1_q.push_back(e[i]);
            else exp2_q.push_back(e[i]);
        end
    endtask

    // Payload scoreboard and event counters.
    always @(negedge clk) begin
        if (o1_w_en) begin
            if (exp1_q.size() == 0) chk("wr1_unexpected", {o1_addr, o1_byte}, 32'hFFFF);
            else chk("wr1", {o1_addr, o1_byte}, exp1_q.pop_front());
        end
        if (o2_w_en) begin
            if (exp2_q.size() == 0) chk("wr2_unexpected", {o2_addr, o2_byte}, 32'hFFFF);
            else chk("wr2", {o2_addr, o2_byte}, exp2_q.pop_front());
        end
        if (o1_start && o1_w_en) chk("start_wen_excl1", 1, 0);
        if (o2_start && o2_w_en) chk("start_wen_excl2", 1, 0);
        if (o1_start) n_start1++;
        if (o2_start) n_start2++;
        if (o1_ovr) n_ovr1++;
        if (o2_ovr) n_ovr2++;
        if (o2_to) n_to2++;
    end

    task automatic wait_ev(input string tag, input int sel, input int bound, output int c);
        c = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((sel == 0 && o1_start) || (sel == 1 && o1_to) || (sel == 2 && o2_start)) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk({tag, "_timed_out"}, 0, 1);
    endtask

    task automatic send_ev(input logic [2:0] code);
        i_ev = code;
        i_ev_sig = 1'b1;
        @(posedge clk);
        #1 i_ev_sig = 1'b0;
    endtask

    int t_en, s1, s2, s3, s4, s5, tt, t1, t2, ns;

    initial begin
        reset = 1'b1; i_enable = 1'b0; i_enable2 = 1'b0;
        i_node_id = 8'h3C; i_ev = 3'd0; i_ev_sig = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outs", {o1_start, o1_w_en, o1_addr, o1_byte, o1_ind, o1_sfd, o1_busy, o1_to, o1_ovr}, 0);
        chk("reset_seq", o1_seq, 0);
        repeat (5) @(negedge clk);
        chk("idle_hold", {o1_busy, o1_w_en, o1_start}, 0);

        // Scenario 1: first beacon immediately after enable
        push_pl(1, 16'h0000);
        @(posedge clk);
        #1 i_enable = 1'b1; t_en = cyc;
        wait_ev("start1", 0, 20, s1);
        chk("start1_latency", s1 - t_en, 5);
        @(posedge clk); #1;
        send_ev(EV_SFD);
        @(negedge clk);
        chk("sfd_set", o1_sfd, 1);
        #1 send_ev(EV_OTHER);
        @(negedge clk);
        chk("other_ev_ignored", {o1_sfd, o1_busy, o1_ind}, 3'b110);
        push_pl(1, 16'h0001);
        #1 send_ev(EV_END);
        @(negedge clk);
        chk("end1_ind", o1_ind, 1);
        chk("end1_seq", o1_seq, 1);
        chk("end1_sfd_busy", {o1_sfd, o1_busy}, 0);

        // Scenario 2: END 20 cycles after start, period spacing
        wait_ev("start2", 0, 150, s2);
        chk("period_1_2", s2 - s1, 100);
        push_pl(1, 16'h0002);
        repeat (19) @(posedge clk);
        #1 send_ev(EV_END);
        @(negedge clk);
        chk("end2_seq_ind", {o1_seq, o1_ind}, {16'd2, 1'b0});
        wait_ev("start3", 0, 150, s3);
        chk("period_2_3", s3 - s2, 100);

        // Scenario 3: no END, timeout
        @(posedge clk); #1;
        send_ev(EV_SFD);
        push_pl(1, 16'h0002);
        wait_ev("timeout3", 1, 80, tt);
        chk("timeout_time", tt - s3, 51);
        chk("timeout_hold", {o1_seq, o1_ind, o1_sfd, o1_busy}, {16'd2, 3'b000});
        @(negedge clk);
        chk("timeout_one_cycle", o1_to, 0);
        wait_ev("start4", 0, 150, s4);
        chk("period_3_4", s4 - s3, 100);

        // Scenario 5: seq wrap via force
        repeat (9) @(posedge clk);
        #1 send_ev(EV_END);
        @(negedge clk);
        chk("end4_seq_ind", {o1_seq, o1_ind}, {16'd3, 1'b1});
        @(posedge clk);
        #1 force dut1.r_seq = 16'hFFFF;
        @(posedge clk);
        #1 release dut1.r_seq;
        @(negedge clk);
        chk("seq_preload", o1_seq, 16'hFFFF);
        push_pl(1, 16'hFFFF);
        wait_ev("start5", 0, 150, s5);
        chk("period_4_5", s5 - s4, 100);

        // Scenario 6: enable drop during WAIT_TX completes to IDLE
        @(posedge clk);
        #1 i_enable = 1'b0;
        @(negedge clk);
        chk("no_abort_busy", o1_busy, 1);
        repeat (5) @(posedge clk);
        #1 send_ev(EV_END);
        @(negedge clk);
        chk("wrap_seq", o1_seq, 16'h0000);
        chk("end5_ind_busy", {o1_ind, o1_busy}, 0);
        ns = n_start1;
        repeat (150) @(negedge clk);
        chk("idle_no_start", n_start1 - ns, 0);

        // Reset during LOAD: two writes then nothing
        exp1_q.push_back({7'd0, 8'hA5});
        exp1_q.push_back({7'd1, 8'h3C});
        @(posedge clk);
        #1 i_enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_load", {o1_start, o1_w_en, o1_addr, o1_byte, o1_ind, o1_sfd, o1_busy, o1_to, o1_ovr}, 0);
        chk("reset_mid_seq", o1_seq, 0);
        i_enable = 1'b0;
        repeat (20) @(negedge clk);
        #1 reset = 1'b0;
        chk("reset_no_start", n_start1 - ns, 0);
        chk("sb1_empty", exp1_q.size(), 0);

        // Scenario 4: late END on TIMEOUT=200 instance
        push_pl(2, 16'h0000);
        @(posedge clk);
        #1 i_enable2 = 1'b1;
        wait_ev("d2_start1", 2, 20, t1);
        repeat (119) @(posedge clk);
        #1 send_ev(EV_END);
        @(negedge clk);
        chk("d2_seq_once", o2_seq, 1);
        chk("d2_overrun", n_ovr2, 1);
        chk("d2_no_extra_start", n_start2, 1);
        chk("d2_no_timeout", n_to2, 0);
        push_pl(2, 16'h0001);
        wait_ev("d2_start2", 2, 150, t2);
        chk("d2_period", t2 - t1, 200);
        chk("d2_seq_hold", o2_seq, 1);
        i_enable2 = 1'b0;
        chk("d1_no_overrun", n_ovr1, 0);
        chk("sb2_empty", exp2_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
